// File: rtl/sap1_pkg.sv
// ============================================================================
// Module      : sap1_pkg
// Description : SAP-1 opcodes, control-bit positions and named control words.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CP   = 11;
    localparam int EP   = 10;
    localparam int LM_N = 9;
    localparam int CE_N = 8;
    localparam int LI_N = 7;
    localparam int EI_N = 6;
    localparam int LA_N = 5;
    localparam int EA   = 4;
    localparam int SU   = 3;
    localparam int EU   = 2;
    localparam int LB_N = 1;
    localparam int LO_N = 0;

    localparam int NUM_T = 6;

    typedef enum logic [NUM_T-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    function automatic logic [11:0] bit_mask(input int idx);
        return 12'd1 << idx;
    endfunction

    // Every word is the idle word with the asserted signals toggled, so
    // active-low and active-high bits are handled uniformly.
    localparam logic [11:0] CW_IDLE   = 12'h3E3;
    localparam logic [11:0] CW_T1     = CW_IDLE ^ bit_mask(EP) ^ bit_mask(LM_N);
    localparam logic [11:0] CW_T2     = CW_IDLE ^ bit_mask(CP);
    localparam logic [11:0] CW_T3     = CW_IDLE ^ bit_mask(CE_N) ^ bit_mask(LI_N);
    localparam logic [11:0] CW_ADDR   = CW_IDLE ^ bit_mask(EI_N) ^ bit_mask(LM_N);
    localparam logic [11:0] CW_LDA_T5 = CW_IDLE ^ bit_mask(CE_N) ^ bit_mask(LA_N);
    localparam logic [11:0] CW_ADD_T5 = CW_IDLE ^ bit_mask(CE_N) ^ bit_mask(LB_N);
    localparam logic [11:0] CW_ADD_T6 = CW_IDLE ^ bit_mask(LA_N) ^ bit_mask(EU);
    localparam logic [11:0] CW_SUB_T6 = CW_ADD_T6 ^ bit_mask(SU);
    localparam logic [11:0] CW_OUT_T4 = CW_IDLE ^ bit_mask(EA) ^ bit_mask(LO_N);

    function automatic logic is_one_hot(input logic [NUM_T-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ring_counter.sv
// ============================================================================
// Module      : ring_counter
// Description : Six-state one-hot T-state ring with hold and self-recovery.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ring_counter
    import sap1_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             hold,
    output logic [NUM_T-1:0] state
);

    // Recovery outranks hold so a corrupted ring cannot stay frozen.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= T1;
        end else if (!is_one_hot(state)) begin
            state <= T1;
        end else if (!hold) begin
            state <= {state[NUM_T-2:0], state[NUM_T-1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/controller_sequencer.sv
// ============================================================================
// Module      : controller_sequencer
// Description : SAP-1 control-word decode from T-state and opcode, plus halt.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module controller_sequencer
    import sap1_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  seq,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        hlt
);

    logic halted;
    logic hlt_now;

    assign hlt_now = (t_state == T4) && (seq == OP_HLT);

    ring_counter u_ring (
        .clk   (clk),
        .clr   (clr),
        .hold  (halted | hlt_now),
        .state (t_state)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            halted <= 1'b0;
        end else if (hlt_now) begin
            halted <= 1'b1;
        end
    end

    // hlt rises combinationally on T4 entry; the flag keeps it up afterwards.
    assign hlt = !clr && (halted || hlt_now);

    always_comb begin
        con = CW_IDLE;
        if (!clr) begin
            case (t_state)
                T1: con = CW_T1;
                T2: con = CW_T2;
                T3: con = CW_T3;
                T4: begin
                    case (seq)
                        OP_LDA, OP_ADD, OP_SUB: con = CW_ADDR;
                        OP_OUT:                 con = CW_OUT_T4;
                        default:                con = CW_IDLE;
                    endcase
                end
                T5: begin
                    case (seq)
                        OP_LDA:         con = CW_LDA_T5;
                        OP_ADD, OP_SUB: con = CW_ADD_T5;
                        default:        con = CW_IDLE;
                    endcase
                end
                T6: begin
                    case (seq)
                        OP_ADD:  con = CW_ADD_T6;
                        OP_SUB:  con = CW_SUB_T6;
                        default: con = CW_IDLE;
                    endcase
                end
                default: con = CW_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
